// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg
//   Shared definitions for the gray_counter slice.
//   DEFAULT_BIT : default counter width (binary and Gray outputs).
//   count_op_e  : the step selected for the next rising edge when not in reset.
//   bin2gray()  : reflected-binary conversion, x ^ (x >> 1), for any width up to 32.
package gray_counter_pkg;

  localparam int DEFAULT_BIT = 8;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } count_op_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// bin_to_gray
//   Purely combinational binary-to-Gray converter.
//   Ports:
//     i_bin  in  BIT : binary value
//     o_gray out BIT : reflected Gray code of i_bin
module bin_to_gray #(
  parameter int BIT = gray_counter_pkg::DEFAULT_BIT
) (
  input  logic [BIT-1:0] i_bin,
  output logic [BIT-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// gray_counter
//   Registered binary/Gray up-down counter with synchronous load.
//   Priority on each rising edge: reset > load > enable > hold.
//   Ports:
//     i_clk      in  1   : clock, rising edge
//     i_rst      in  1   : synchronous active-high reset
//     i_en       in  1   : count enable, one step per cycle
//     i_dir      in  1   : 1 = count up, 0 = count down
//     i_load     in  1   : load i_load_bin (overrides i_en)
//     i_load_bin in  BIT : value to load
//     o_bin      out BIT : registered binary count
//     o_gray     out BIT : registered Gray code of o_bin
//     o_wrap     out 1   : pulse, previous edge stepped across all-ones/zero
//     o_step     out 1   : pulse, previous edge performed a count step
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int BIT = DEFAULT_BIT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic           i_dir,
  input  logic           i_load,
  input  logic [BIT-1:0] i_load_bin,
  output logic [BIT-1:0] o_bin,
  output logic [BIT-1:0] o_gray,
  output logic           o_wrap,
  output logic           o_step
);

  localparam logic [BIT-1:0] ONE = BIT'(1);

  count_op_e      op;
  logic [BIT-1:0] next_bin;
  logic [BIT-1:0] next_gray;
  logic           next_wrap;
  logic           next_step;

  // Select the operation for this edge; load beats enable.
  always_comb begin
    op = OP_HOLD;
    if (i_load) begin
      op = OP_LOAD;
    end else if (i_en) begin
      op = i_dir ? OP_UP : OP_DOWN;
    end
  end

  // Next-state mux: wrap is detected on the current value before stepping.
  always_comb begin
    next_bin  = o_bin;
    next_wrap = 1'b0;
    next_step = 1'b0;
    unique case (op)
      OP_LOAD: begin
        next_bin = i_load_bin;
      end
      OP_UP: begin
        next_bin  = o_bin + ONE;
        next_wrap = &o_bin;
        next_step = 1'b1;
      end
      OP_DOWN: begin
        next_bin  = o_bin - ONE;
        next_wrap = ~|o_bin;
        next_step = 1'b1;
      end
      default: begin
        next_bin = o_bin;
      end
    endcase
  end

  // Gray is taken from the next binary value so both registers update on
  // the same edge; deriving it from o_bin would lag by one cycle.
  bin_to_gray #(
    .BIT(BIT)
  ) u_bin_to_gray (
    .i_bin (next_bin),
    .o_gray(next_gray)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bin  <= '0;
      o_gray <= '0;
      o_wrap <= 1'b0;
      o_step <= 1'b0;
    end else begin
      o_bin  <= next_bin;
      o_gray <= next_gray;
      o_wrap <= next_wrap;
      o_step <= next_step;
    end
  end

endmodule
